// File: rtl/div_reconstruct_if.sv
// Operand/result bundle for div_reconstruct: start request, q/r/d operands,
// and busy/done/a_out/ovf status.
interface div_reconstruct_if #(
  parameter int DATAWIDTH = 64
);
  logic                        start;
  logic signed [DATAWIDTH-1:0] q;
  logic signed [DATAWIDTH-1:0] r;
  logic signed [DATAWIDTH-1:0] d;
  logic                        busy;
  logic                        done;
  logic signed [DATAWIDTH-1:0] a_out;
  logic                        ovf;

  modport master (
    output start, q, r, d,
    input  busy, done, a_out, ovf
  );

  modport slave (
    input  start, q, r, d,
    output busy, done, a_out, ovf
  );
endinterface

// File: rtl/div_reconstruct.sv
// Rebuilds the dividend a = q*d + r from a signed truncating quotient/remainder
// pair using a sequential shift-add multiplier on sign-magnitude operands.
module div_reconstruct #(
  parameter int DATAWIDTH = 64
) (
  input  logic            clk,
  input  logic            rst,
  div_reconstruct_if.slave bus
);

  localparam int unsigned MW = DATAWIDTH + 1;       // operand magnitude width
  localparam int unsigned AW = 2 * DATAWIDTH + 1;   // product accumulator width
  localparam int unsigned SW = 2 * DATAWIDTH + 2;   // final signed sum width
  localparam int unsigned CW = $clog2(DATAWIDTH);   // iteration counter width

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t                r_state;
  state_t                w_state_nxt;
  logic                  w_accept;
  logic                  w_last;

  logic [CW-1:0]         r_cnt;
  logic                  r_neg;
  logic [MW-1:0]         r_mplier;
  logic [AW-1:0]         r_mcand;
  logic [AW-1:0]         r_acc;
  logic [DATAWIDTH-1:0]  r_rop;
  logic [DATAWIDTH-1:0]  r_aout;
  logic                  r_ovf;
  logic                  r_busy;
  logic                  r_done;

  logic [MW-1:0]         w_qext;
  logic [MW-1:0]         w_dext;
  logic [MW-1:0]         w_qmag;
  logic [MW-1:0]         w_dmag;
  logic [SW-1:0]         w_prod_ext;
  logic [SW-1:0]         w_prod_sgn;
  logic [SW-1:0]         w_rext;
  logic [SW-1:0]         w_sum;
  logic [DATAWIDTH-1:0]  w_low;
  logic                  w_ovf;

  // Magnitudes are one bit wider so that -2^(DATAWIDTH-1) negates exactly.
  always_comb begin
    w_qext = {bus.q[DATAWIDTH-1], bus.q};
    w_dext = {bus.d[DATAWIDTH-1], bus.d};
    w_qmag = bus.q[DATAWIDTH-1] ? MW'(~w_qext + MW'(1)) : w_qext;
    w_dmag = bus.d[DATAWIDTH-1] ? MW'(~w_dext + MW'(1)) : w_dext;
  end

  // Sign fix-up, remainder add and overflow detection for the FIX state.
  always_comb begin
    w_prod_ext = SW'(r_acc);
    w_prod_sgn = r_neg ? SW'(~w_prod_ext + SW'(1)) : w_prod_ext;
    w_rext     = {{(SW - DATAWIDTH){r_rop[DATAWIDTH-1]}}, r_rop};
    w_sum      = w_prod_sgn + w_rext;
    w_low      = w_sum[DATAWIDTH-1:0];
    w_ovf      = (w_sum != {{(SW - DATAWIDTH){w_low[DATAWIDTH-1]}}, w_low});
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_last      = (r_cnt == CW'(DATAWIDTH - 1));
    case (r_state)
      IDLE: begin
        if (bus.start) begin
          w_state_nxt = RUN;
          w_accept    = 1'b1;
        end
      end
      RUN: begin
        if (w_last) begin
          w_state_nxt = FIX;
        end
      end
      FIX: begin
        w_state_nxt = DONE;
      end
      DONE: begin
        if (bus.start) begin
          w_state_nxt = RUN;
          w_accept    = 1'b1;
        end else begin
          w_state_nxt = IDLE;
        end
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  // Datapath; status flags are registered from the next state so they track it exactly.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt    <= '0;
      r_neg    <= 1'b0;
      r_mplier <= '0;
      r_mcand  <= '0;
      r_acc    <= '0;
      r_rop    <= '0;
      r_aout   <= '0;
      r_ovf    <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_busy <= (w_state_nxt == RUN) || (w_state_nxt == FIX);
      r_done <= (w_state_nxt == DONE);
      if (w_accept) begin
        r_neg    <= bus.q[DATAWIDTH-1] ^ bus.d[DATAWIDTH-1];
        r_mplier <= w_qmag;
        r_mcand  <= AW'(w_dmag);
        r_acc    <= '0;
        r_cnt    <= '0;
        r_rop    <= bus.r;
      end else if (r_state == RUN) begin
        r_acc    <= r_acc + (r_mplier[0] ? r_mcand : '0);
        r_mcand  <= r_mcand << 1;
        r_mplier <= r_mplier >> 1;
        r_cnt    <= r_cnt + CW'(1);
      end else if (r_state == FIX) begin
        r_aout <= w_low;
        r_ovf  <= w_ovf;
      end
    end
  end

  assign bus.busy  = r_busy;
  assign bus.done  = r_done;
  assign bus.a_out = r_aout;
  assign bus.ovf   = r_ovf;

endmodule

// File: doc/div_reconstruct.md
DIV_RECONSTRUCT -- requirements
Module: div_reconstruct

Interface
REQ-001 The block SHALL have parameter: DATAWIDTH, 64, operand/result width in bits (legal range 8..64).
REQ-002 The block SHALL have port: clk  input  1  single clock for all state; rising edge active.
REQ-003 The block SHALL have port: rst  input  1  asynchronous, active-high reset.
REQ-004 The block SHALL have port: start  input  1  request; sampled on a rising clk edge when busy=0.
REQ-005 The block SHALL have port: q  input  signed DATAWIDTH  quotient operand.
REQ-006 The block SHALL have port: r  input  signed DATAWIDTH  remainder operand.
REQ-007 The block SHALL have port: d  input  signed DATAWIDTH  divisor operand.
REQ-008 The block SHALL have port: busy  output  1  high while an operation is in progress.
REQ-009 The block SHALL have port: done  output  1  one-cycle pulse marking a valid a_out.
REQ-010 The block SHALL have port: a_out  output  signed DATAWIDTH  reconstructed dividend q*d + r, registered.
REQ-011 The block SHALL have port: ovf  output  1  high when the exact q*d + r does not fit in DATAWIDTH signed bits.

Function
REQ-012 The block SHALL compute a_out = q*d + r (two's complement), the inverse of signed truncating divide/modulo, so that a = (a/b)*b + (a%b).
REQ-013 The FSM SHALL have states IDLE, RUN, FIX, DONE; IDLE->RUN on start; RUN->FIX after DATAWIDTH iterations; FIX->DONE unconditionally; DONE->RUN on start, else DONE->IDLE.
REQ-014 On the edge accepting start, the block SHALL latch q, r, d, record sign(q) XOR sign(d), load |q| and |d| as DATAWIDTH+1-bit unsigned magnitudes, and clear the iteration counter.
REQ-015 In RUN, the block SHALL perform one shift-add multiply step per cycle (one multiplier bit per cycle, LSB first) into a 2*DATAWIDTH+1-bit accumulator.
REQ-016 In FIX, the block SHALL negate the product when the recorded sign is 1, add r sign-extended to 2*DATAWIDTH+2 bits, write the low DATAWIDTH bits to a_out, and set ovf=1 iff the full sum differs from sign-extension of those low bits.
REQ-017 done SHALL be high exactly during the DONE state; latency from the start-sampling edge to the edge on which done is first seen high SHALL be DATAWIDTH+2 clock edges.
REQ-018 busy SHALL be high in RUN and FIX and low in IDLE and DONE.
REQ-019 start while busy=1 SHALL be ignored; operands changing while busy=1 SHALL NOT affect the result.
REQ-020 start in the DONE cycle SHALL be accepted (back-to-back operation, no idle cycle).
REQ-021 a_out and ovf SHALL hold their last values until the next FIX state updates them.
REQ-022 d=0 or q=0 SHALL yield a_out=r, ovf=0, with normal latency.
REQ-023 q or d equal to -2^(DATAWIDTH-1) SHALL be handled exactly via the DATAWIDTH+1-bit magnitudes.

Reset
REQ-024 rst=1 SHALL immediately force state IDLE, busy=0, done=0, a_out=0, ovf=0, clearing all internal registers, independent of clk.
REQ-025 rst asserted mid-operation SHALL abort it; no done pulse SHALL follow for that operation.
REQ-026 After rst deasserts, the first rising clk edge with start=1 SHALL begin a new operation.

Verification
REQ-027 q=7, d=3, r=1, start one cycle -> busy high, done pulse after 66 edges, a_out=22, ovf=0.
REQ-028 q=-14, d=7, r=-2 -> a_out=-100, ovf=0; q=-7, d=-3, r=-1 -> a_out=20, ovf=0.
REQ-029 q=12345, d=0, r=5 -> a_out=5, ovf=0; q=2^62, d=4, r=0 -> a_out=0, ovf=1; q=-2^63, d=1, r=0 -> a_out=-2^63, ovf=0.
REQ-030 start re-pulsed with new operands at RUN cycle 10 -> ignored, original result returned; start held high through DONE -> second operation begins with no gap.
REQ-031 rst asserted between clock edges at RUN cycle 20 -> busy=0, a_out=0 immediately; no done pulse; next operation q=3, d=3, r=0 -> a_out=9.
REQ-032 Random signed a, nonzero b: feed q=a/b, r=a%b (truncating), d=b -> a_out=a, ovf=0 for 10,000 vectors.
